// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and helpers for the round-robin single-port RAM arbiter.
// The response stage carries the issuing port so read data can be steered back.
package sp_ram_arbiter_pkg;

    localparam int PORT_IDX_W_MAX = 4;  // enough for 16 requesters

    function automatic int port_idx_w(input int n_ports);
        int w;
        w = $clog2(n_ports);
        return (w < 1) ? 1 : w;
    endfunction

    // Port field is sized for the largest supported arbiter; unused high bits stay zero.
    typedef struct packed {
        logic                      vld;
        logic [PORT_IDX_W_MAX-1:0] port;
    } rsp_stage_t;

endpackage

// File: rtl/SyncSpRam.sv
// Synchronous single-port RAM with optional output register.
// One access per cycle: write when WrEn_SI, otherwise read; out-of-range accesses are ignored.
module SyncSpRam #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REGS   = 0,
    parameter int SIM_INIT   = 0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  CSel_SI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [DATA_WIDTH-1:0] WrData_DI,
    output logic [DATA_WIDTH-1:0] RdData_DO
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  in_range;

    assign in_range = ({1'b0, Addr_DI} < (ADDR_WIDTH + 1)'(DATA_DEPTH));

    always_ff @(posedge Clk_CI) begin
        if (CSel_SI && in_range) begin
            if (WrEn_SI) mem[Addr_DI] <= WrData_DI;
            else         rd_q         <= mem[Addr_DI];
        end
    end

    generate
        if (OUT_REGS != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
                if (!Rst_RBI) out_q <= '0;
                else          out_q <= rd_q;
            end
            assign RdData_DO = out_q;
        end else begin : g_no_out_reg
            assign RdData_DO = rd_q;
        end
    endgenerate

    addr_in_range_a: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
        CSel_SI |-> in_range);
    sim_init_legal_a: assert property (@(posedge Clk_CI) SIM_INIT inside {0, 1, 2});

endmodule

// File: rtl/sp_rr_select.sv
// Rotating-priority picker: first requester found starting at ptr, wrapping modulo N_PORTS.
module sp_rr_select
    import sp_ram_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = port_idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int p;

    // Walk from the farthest offset toward ptr so the closest requester is the last write.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int off = N_PORTS - 1; off >= 0; off--) begin
            p = (int'(ptr) + off) % N_PORTS;
            if (req[p]) begin
                gnt    = '0;
                gnt[p] = 1'b1;
                idx    = IDX_W'(p);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin sharing of one SyncSpRam between N_PORTS requesters.
// Read responses travel a RD_LAT-deep {valid, port} pipeline aligned with the RAM read data.
module sp_ram_arbiter
    import sp_ram_arbiter_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REGS   = 0,
    parameter int SIM_INIT   = 0
) (
    input  logic                                 Clk_CI,
    input  logic                                 Rst_RBI,
    input  logic [N_PORTS-1:0]                   Req_SI,
    input  logic [N_PORTS-1:0]                   We_SI,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   Addr_DI,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   WrData_DI,
    output logic [N_PORTS-1:0]                   Gnt_SO,
    output logic [N_PORTS-1:0]                   RVld_SO,
    output logic [DATA_WIDTH-1:0]                RData_DO,
    output logic                                 Busy_SO
);

    localparam int PORT_IDX_W = port_idx_w(N_PORTS);
    localparam int RD_LAT     = 1 + OUT_REGS;

    logic [PORT_IDX_W-1:0] Prio_SP;
    logic [PORT_IDX_W-1:0] win_idx;
    logic                  win_any;
    logic                  rd_fire;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    rsp_stage_t            rsp_pipe [RD_LAT];

    sp_rr_select #(
        .N_PORTS (N_PORTS),
        .IDX_W   (PORT_IDX_W)
    ) u_sel (
        .req (Req_SI),
        .ptr (Prio_SP),
        .gnt (Gnt_SO),
        .idx (win_idx),
        .any (win_any)
    );

    assign ram_we    = We_SI[win_idx];
    assign ram_addr  = Addr_DI[win_idx];
    assign ram_wdata = WrData_DI[win_idx];
    assign rd_fire   = win_any && !ram_we;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Prio_SP <= '0;
        end else if (win_any) begin
            Prio_SP <= (win_idx == PORT_IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Response pipeline never stalls; its depth matches the RAM read latency.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int s = 0; s < RD_LAT; s++) rsp_pipe[s] <= '0;
        end else begin
            rsp_pipe[0] <= '{vld: rd_fire, port: PORT_IDX_W_MAX'(win_idx)};
            for (int s = 1; s < RD_LAT; s++) rsp_pipe[s] <= rsp_pipe[s-1];
        end
    end

    always_comb begin
        RVld_SO = '0;
        Busy_SO = 1'b0;
        for (int p = 0; p < N_PORTS; p++)
            RVld_SO[p] = rsp_pipe[RD_LAT-1].vld && (rsp_pipe[RD_LAT-1].port == PORT_IDX_W_MAX'(p));
        for (int s = 0; s < RD_LAT; s++)
            Busy_SO = Busy_SO | rsp_pipe[s].vld;
    end

    SyncSpRam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REGS   (OUT_REGS),
        .SIM_INIT   (SIM_INIT)
    ) u_ram (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .CSel_SI   (win_any),
        .WrEn_SI   (ram_we),
        .Addr_DI   (ram_addr),
        .WrData_DI (ram_wdata),
        .RdData_DO (RData_DO)
    );

    gnt_onehot0_a:  assert property (@(posedge Clk_CI) disable iff (!Rst_RBI) $onehot0(Gnt_SO));
    rvld_onehot0_a: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI) $onehot0(RVld_SO));
    gnt_has_req_a:  assert property (@(posedge Clk_CI) disable iff (!Rst_RBI) (Gnt_SO & ~Req_SI) == '0);
    out_regs_a:     assert property (@(posedge Clk_CI) OUT_REGS inside {0, 1});

endmodule
